// File: rtl/cache_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of two write-back sources into an
// external write buffer, and a drain engine that retires buffered entries to memory.
module cache_wb_scheduler #(
    parameter int FIFO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [FIFO_WIDTH-1:0] req0_data,
    input  logic [FIFO_WIDTH-1:0] req0_addr,
    input  logic [FIFO_WIDTH-1:0] req1_data,
    input  logic [FIFO_WIDTH-1:0] req1_addr,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_push,
    output logic [FIFO_WIDTH-1:0] fifo_wdata,
    output logic [FIFO_WIDTH-1:0] fifo_waddr,
    output logic                  fifo_pop,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    input  logic [FIFO_WIDTH-1:0] fifo_raddr,
    output logic                  mem_req,
    output logic [FIFO_WIDTH-1:0] mem_addr,
    output logic [FIFO_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    rr_r;
    logic                    flush_pending_r;
    logic                    flush_done_r;
    logic                    mem_req_r;
    logic [FIFO_WIDTH-1:0]   mem_addr_r;
    logic [FIFO_WIDTH-1:0]   mem_wdata_r;
    logic                    grant_ok_s;
    logic                    gnt0_s;
    logic                    gnt1_s;
    logic                    pop_s;
    logic                    done_cond_s;
    logic [FIFO_WIDTH-1:0]   wdata_s;
    logic [FIFO_WIDTH-1:0]   waddr_s;

    // Push arbitration; rst_n gates grants so nothing leaks out while reset is low
    always_comb begin
        grant_ok_s = rst_n & ~fifo_full & ~flush_pending_r;
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        if (grant_ok_s) begin
            if (req0 && req1) begin
                gnt0_s = ~rr_r;
                gnt1_s = rr_r;
            end else begin
                gnt0_s = req0;
                gnt1_s = req1;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Payload mux toward the write buffer; zero when idle
    always_comb begin
        wdata_s = {FIFO_WIDTH{1'b0}};
        waddr_s = {FIFO_WIDTH{1'b0}};
        if (gnt0_s) begin
            wdata_s = req0_data;
            waddr_s = req0_addr;
        end else if (gnt1_s) begin
            wdata_s = req1_data;
            waddr_s = req1_addr;
        end else begin
            wdata_s = {FIFO_WIDTH{1'b0}};
            waddr_s = {FIFO_WIDTH{1'b0}};
        end
    end

    // Round-robin pointer flips to the port that did not just win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (gnt0_s) begin
            rr_r <= 1'b1;
        end else if (gnt1_s) begin
            rr_r <= 1'b0;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Drain FSM next state and pop strobe
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_s       = rst_n;
                    state_nxt_s = ST_LOAD;
                end else begin
                    pop_s       = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Memory request registers; address/data are kept after the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            mem_addr_r  <= {FIFO_WIDTH{1'b0}};
            mem_wdata_r <= {FIFO_WIDTH{1'b0}};
        end else if (state_r == ST_LOAD) begin
            mem_req_r   <= 1'b1;
            mem_addr_r  <= fifo_raddr;
            mem_wdata_r <= fifo_rdata;
        end else if ((state_r == ST_ISSUE) && mem_ack) begin
            mem_req_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_r;
        end
    end

    // A flush completes only once nothing is queued, in flight or being pushed
    assign done_cond_s = flush_pending_r & (state_r == ST_IDLE) & fifo_empty & ~fifo_push;

    // Flush tracking: one completion pulse per pending episode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
        end else begin
            flush_done_r <= done_cond_s;
            if (done_cond_s) begin
                flush_pending_r <= 1'b0;
            end else if (flush) begin
                flush_pending_r <= 1'b1;
            end else begin
                flush_pending_r <= flush_pending_r;
            end
        end
    end

    assign gnt0       = gnt0_s;
    assign gnt1       = gnt1_s;
    assign fifo_push  = gnt0_s | gnt1_s;
    assign fifo_wdata = wdata_s;
    assign fifo_waddr = waddr_s;
    assign fifo_pop   = pop_s;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign flush_done = flush_done_r;
    assign busy       = (state_r != ST_IDLE) | ~fifo_empty | flush_pending_r;

endmodule

// File: tb/tb_cache_wb_scheduler.sv
// Bench for cache_wb_scheduler: queue-based write buffer and memory responder,
// a per-cycle reference model, and directed scenarios with literal expectations.
module tb_cache_wb_scheduler;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n, req0, req1, flush;
    logic [W-1:0] req0_data, req0_addr, req1_data, req1_addr;
    logic         gnt0, gnt1, fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic         mem_req, mem_ack, flush_done, busy;
    logic [W-1:0] fifo_wdata, fifo_waddr, mem_addr, mem_wdata;
    logic [W-1:0] fifo_rdata = '0;
    logic [W-1:0] fifo_raddr = '0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_addr[$];
    logic [W-1:0] q_data[$];
    int           qcount     = 0;
    logic         force_full = 1'b0;
    logic         ack_tied   = 1'b0;
    logic         ack_ok     = 1'b0;
    int           ack_delay  = 0;
    int           wait_cnt   = 0;
    logic         env_push   = 1'b0;
    logic         env_pop    = 1'b0;
    logic [W-1:0] env_paddr  = '0;
    logic [W-1:0] env_pdata  = '0;

    assign fifo_empty = (qcount == 0);
    assign fifo_full  = force_full | (qcount >= DEPTH);
    assign mem_ack    = ack_tied | (mem_req & ack_ok);

    cache_wb_scheduler #(.FIFO_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .req0_data(req0_data), .req0_addr(req0_addr),
        .req1_data(req1_data), .req1_addr(req1_addr),
        .gnt0(gnt0), .gnt1(gnt1),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_waddr(fifo_waddr),
        .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .fifo_raddr(fifo_raddr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || qcount != 0) && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (busy || qcount != 0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b qcount=%0d after %0d cycles, expected idle", busy, qcount, n);
        end
    endtask

    task automatic wait_mem_req(input int lim);
        int n = 0;
        while (!mem_req && n < lim) begin
            tick();
            n++;
        end
        chk1("mem_req_seen", mem_req, 1'b1);
    endtask

    // External write buffer and memory responder react to what the DUT strobed
    always @(posedge clk) begin
        #1;
        if (env_pop && q_addr.size() > 0) begin
            fifo_raddr = q_addr.pop_front();
            fifo_rdata = q_data.pop_front();
        end
        if (env_push) begin
            q_addr.push_back(env_paddr);
            q_data.push_back(env_pdata);
        end
        qcount = q_addr.size();
        if (mem_req) wait_cnt = wait_cnt + 1;
        else wait_cnt = 0;
        ack_ok = (wait_cnt > ack_delay);
    end

    // Reference model: last winner, entry in flight with its age, pending flush
    logic         m_pend     = 1'b0;
    logic         m_done     = 1'b0;
    logic         m_inflight = 1'b0;
    int           m_last     = 1;
    int           m_age      = 0;
    logic [W-1:0] m_cur_a = '0, m_cur_d = '0, m_show_a = '0, m_show_d = '0;

    always @(negedge clk) begin
        logic         ok, e_g0, e_g1, e_push, e_pop, e_req, e_busy, e_cond;
        logic [W-1:0] e_wa, e_wd;
        if (!rst_n) begin
            chk1("cyc_rst_gnt0", gnt0, 1'b0);
            chk1("cyc_rst_gnt1", gnt1, 1'b0);
            chk1("cyc_rst_push", fifo_push, 1'b0);
            chk32("cyc_rst_wdata", fifo_wdata, 32'h0);
            chk1("cyc_rst_pop", fifo_pop, 1'b0);
            chk1("cyc_rst_mem_req", mem_req, 1'b0);
            chk32("cyc_rst_mem_addr", mem_addr, 32'h0);
            chk32("cyc_rst_mem_wdata", mem_wdata, 32'h0);
            chk1("cyc_rst_flush_done", flush_done, 1'b0);
            chk1("cyc_rst_busy", busy, !fifo_empty);
            m_pend = 1'b0; m_done = 1'b0; m_inflight = 1'b0; m_last = 1; m_age = 0;
            m_show_a = '0; m_show_d = '0;
        end else begin
            ok     = !fifo_full && !m_pend;
            e_g0   = ok && req0 && (!req1 || m_last == 1);
            e_g1   = ok && req1 && (!req0 || m_last == 0);
            e_push = e_g0 || e_g1;
            e_wa   = e_g0 ? req0_addr : (e_g1 ? req1_addr : 32'h0);
            e_wd   = e_g0 ? req0_data : (e_g1 ? req1_data : 32'h0);
            e_pop  = !m_inflight && !fifo_empty;
            e_req  = m_inflight && m_age >= 2;
            e_busy = m_inflight || !fifo_empty || m_pend;
            e_cond = m_pend && !m_inflight && fifo_empty && !e_push;
            chk1("cyc_gnt0", gnt0, e_g0);
            chk1("cyc_gnt1", gnt1, e_g1);
            chk1("cyc_push", fifo_push, e_push);
            chk32("cyc_waddr", fifo_waddr, e_wa);
            chk32("cyc_wdata", fifo_wdata, e_wd);
            chk1("cyc_pop", fifo_pop, e_pop);
            chk1("cyc_mem_req", mem_req, e_req);
            chk32("cyc_mem_addr", mem_addr, m_show_a);
            chk32("cyc_mem_wdata", mem_wdata, m_show_d);
            chk1("cyc_flush_done", flush_done, m_done);
            chk1("cyc_busy", busy, e_busy);
            if (e_g0) m_last = 0;
            else if (e_g1) m_last = 1;
            if (m_inflight) begin
                if (m_age == 1) begin
                    m_show_a = m_cur_a;
                    m_show_d = m_cur_d;
                end
                if (m_age >= 2 && mem_ack) m_inflight = 1'b0;
                m_age++;
            end else if (e_pop) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_cur_a    = q_addr[0];
                m_cur_d    = q_data[0];
            end
            m_done = e_cond;
            if (e_cond) m_pend = 1'b0;
            else if (flush) m_pend = 1'b1;
        end
        env_push  = fifo_push;
        env_pop   = fifo_pop;
        env_paddr = fifo_waddr;
        env_pdata = fifo_wdata;
    end

    initial begin
        int cnt, pops, bad, dn, g;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
        req0_data = '0; req0_addr = '0; req1_data = '0; req1_addr = '0;
        ack_tied = 1'b1; ack_delay = 0; force_full = 1'b0;
        repeat (2) tick();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk1("reset_gnt0", gnt0, 1'b0);
        chk1("reset_gnt1", gnt1, 1'b0);
        chk1("reset_push", fifo_push, 1'b0);
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        tick();

        // Alternating grants, port 0 first after reset release
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_addr = 32'h0000_0010 + k; req0_data = 32'h1111_0000 + k;
            req1_addr = 32'h0000_0020 + k; req1_data = 32'h2222_0000 + k;
            #1;
            chk1("rr_gnt0", gnt0, (k % 2 == 0));
            chk1("rr_gnt1", gnt1, (k % 2 == 1));
            chk32("rr_wdata", fifo_wdata, (k % 2 == 0) ? 32'h1111_0000 + k : 32'h2222_0000 + k);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(60);

        // Full write buffer blocks grants without moving the pointer
        force_full = 1'b1; req0 = 1'b1; req1 = 1'b1;
        req0_addr = 32'h0000_0030; req0_data = 32'h3333_0001;
        req1_addr = 32'h0000_0040; req1_data = 32'h4444_0001;
        #1;
        chk1("full_gnt0", gnt0, 1'b0);
        chk1("full_gnt1", gnt1, 1'b0);
        chk1("full_push", fifo_push, 1'b0);
        tick();
        force_full = 1'b0;
        #1;
        chk1("unfull_gnt0", gnt0, 1'b1);
        chk1("unfull_push", fifo_push, 1'b1);
        tick();
        force_full = 1'b1; req1 = 1'b0;
        #1;
        chk1("full_single_gnt0", gnt0, 1'b0);
        tick();
        force_full = 1'b0;
        #1;
        chk1("unfull_single_gnt0", gnt0, 1'b1);
        tick();
        req0 = 1'b0;
        wait_idle(60);

        // Single entry with ack tied high
        req0 = 1'b1; req0_addr = 32'h0000_0100; req0_data = 32'hDEAD_BEEF;
        #1;
        chk1("p1_gnt0", gnt0, 1'b1);
        tick();
        req0 = 1'b0;
        #1;
        chk1("p1_pop_t", fifo_pop, 1'b1);
        tick(); #1;
        chk1("p1_pop_t1", fifo_pop, 1'b0);
        chk1("p1_req_t1", mem_req, 1'b0);
        tick(); #1;
        chk1("p1_req_t2", mem_req, 1'b1);
        chk32("p1_addr_t2", mem_addr, 32'h0000_0100);
        chk32("p1_data_t2", mem_wdata, 32'hDEAD_BEEF);
        tick(); #1;
        chk1("p1_req_t3", mem_req, 1'b0);
        chk32("p1_addr_kept", mem_addr, 32'h0000_0100);
        chk1("p1_pop_t3", fifo_pop, 1'b0);
        wait_idle(20);

        // Slow acknowledge: request held stable, no second pop meanwhile
        ack_tied = 1'b0; ack_delay = 5;
        req0 = 1'b1; req0_addr = 32'h0000_0200; req0_data = 32'hCAFE_0001;
        tick();
        req0 = 1'b0; req1 = 1'b1; req1_addr = 32'h0000_0300; req1_data = 32'hCAFE_0002;
        tick();
        req1 = 1'b0;
        wait_mem_req(10);
        cnt = 0; pops = 0; bad = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            if (fifo_pop) pops++;
            if (mem_addr !== 32'h0000_0200 || mem_wdata !== 32'hCAFE_0001) bad++;
            tick();
        end
        chk32("stall_cycles", cnt, 32'd6);
        chk32("stall_pops", pops, 32'd0);
        chk32("stall_unstable", bad, 32'd0);
        chk1("second_pop_at_idle", fifo_pop, 1'b1);
        wait_idle(60);

        // Flush with three entries queued behind one in flight
        ack_delay = 2;
        req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_addr = 32'h0000_0400 + 4 * k; req0_data = 32'h5000_0000 + k;
            tick();
        end
        req0 = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; req0 = 1'b1; req0_addr = 32'h0000_0500; req0_data = 32'h5555_AAAA;
        dn = 0; g = 0;
        for (int i = 0; i < 60; i++) begin
            flush = (i == 3);
            #1;
            if (flush_done) begin
                dn++;
                req0 = 1'b0;
                #1;
                chk1("busy_at_flush_done", busy, 1'b0);
            end else if (dn == 0 && gnt0) begin
                g++;
            end
            tick();
        end
        chk32("flush_done_count", dn, 32'd1);
        chk32("gnt0_while_flushing", g, 32'd0);
        chk1("busy_after_flush", busy, 1'b0);

        // Reset in the middle of a write abandons it
        ack_delay = 4;
        req0 = 1'b1; req0_addr = 32'h0000_0600; req0_data = 32'h7777_0001;
        tick();
        req0 = 1'b0;
        wait_mem_req(10);
        tick();
        chk1("issue_before_reset", mem_req, 1'b1);
        rst_n = 1'b0; req0 = 1'b1; req0_addr = 32'h0000_0640; req0_data = 32'h8888_0002;
        #1;
        chk1("async_mem_req", mem_req, 1'b0);
        chk32("async_mem_addr", mem_addr, 32'h0);
        chk32("async_mem_wdata", mem_wdata, 32'h0);
        chk1("async_pop", fifo_pop, 1'b0);
        chk1("async_gnt0", gnt0, 1'b0);
        chk1("async_push", fifo_push, 1'b0);
        chk1("async_busy", busy, 1'b0);
        tick();
        chk1("reset_hold_mem_req", mem_req, 1'b0);
        ack_tied = 1'b1;
        rst_n = 1'b1;
        #1;
        chk1("post_reset_gnt0", gnt0, 1'b1);
        tick();
        req0 = 1'b0;
        wait_idle(40);
        chk32("post_reset_addr", mem_addr, 32'h0000_0640);
        chk32("post_reset_data", mem_wdata, 32'h8888_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
